// File: rtl/add32_seq_pkg.sv
// Shared types and sizing for the byte-serial 32-bit adder sequencer.
package add32_seq_pkg;

   localparam int SLICE_W = 8;
   localparam int NSLICE  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/byte_slice_adder.sv
// Combinational ripple adder slice shared by every byte of the operation.
module byte_slice_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/add32_seq_ctrl.sv
// Byte-serial 32-bit adder: one shared slice walked over NSLICE cycles,
// with valid/ready handshakes on the operand and result sides.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   RUN   | adding slice idx, carry held in carry_q
//   DONE  | result presented with out_valid until out_ready
module add32_seq_ctrl
   import add32_seq_pkg::*;
#(
   parameter int WIDTH = SLICE_W * NSLICE,
   parameter int SLICE = SLICE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NS = WIDTH / SLICE;
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;

   seq_state_t       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [SLICE-1:0] sl_a, sl_b, sl_s;
   logic             sl_co;

   assign sl_a = a_q[int'(idx_q) * SLICE +: SLICE];
   assign sl_b = b_q[int'(idx_q) * SLICE +: SLICE];

   byte_slice_adder #(.W(SLICE)) u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (carry_q),
      .s  (sl_s),
      .co (sl_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[int'(idx_q) * SLICE +: SLICE] = sl_s;
            carry_d = sl_co;
            if (idx_q == IW'(NS - 1)) begin
               cout_d  = sl_co;
               // Overflow only when same-signed operands yield a flipped sign.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sum_d[WIDTH-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Self-checking bench for add32_seq_ctrl: arithmetic reference model with a
// pending-result queue, directed corner cases plus randomized traffic.
module tb_add32_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;

   add32_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   acc_edge = 0;
   int   last_acc = -1;
   int   n_res    = 0;
   bit   seen_valid = 0;
   bit   tput_mode  = 0;
   bit   rnd_done   = 0;
   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
      exp_t        r;
      logic [32:0] t;
      t   = {1'b0, x} + {1'b0, y} + 33'(c);
      r.s = t[31:0];
      r.c = t[32];
      r.o = (x[31] == y[31]) && (t[31] != x[31]);
      return r;
   endfunction

   // Reference monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      bit   pend;
      exp_t e;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         seen_valid = 0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_sum", sum, 0);
         chk("rst_cout", cout, 0);
         chk("rst_ovf", ovf, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_busy", busy, 0);
      end else begin
         pend = (exp_q.size() != 0);
         chk("busy", busy, pend);
         chk("in_ready", in_ready, !pend);
         if (out_valid) begin
            if (!pend) begin
               chk("spurious_out_valid", out_valid, 0);
            end else begin
               e = exp_q[0];
               chk("sum", sum, e.s);
               chk("cout", cout, e.c);
               chk("ovf", ovf, e.o);
               if (!seen_valid) begin
                  chk("latency", cyc - acc_edge, 4);
                  seen_valid = 1;
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  n_res++;
               end
            end
         end else if (pend) begin
            chk("out_valid_late", (cyc - acc_edge) > 3, 0);
         end
         if (in_valid && in_ready) begin
            if (tput_mode && last_acc >= 0) chk("init_interval", cyc - last_acc, 6);
            last_acc   = cyc;
            acc_edge   = cyc + 1;
            seen_valid = 0;
            exp_q.push_back(model(a, b, cin));
         end
      end
   end

   task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic tc,
                        input logic [31:0] es, input logic ec, input logic eo, input int hold);
      bit got;
      @(posedge clk); #1;
      a = ta; b = tbv; cin = tc; in_valid = 1; out_ready = 0;
      @(posedge clk); #1;
      in_valid = 0; a = $urandom; b = $urandom; cin = 1'($urandom);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = out_valid;
      end
      chk("result_timeout", got, 1);
      chk("lit_sum", sum, es);
      chk("lit_cout", cout, ec);
      chk("lit_ovf", ovf, eo);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         in_valid = (i == 3);
         @(negedge clk);
         chk("hold_sum", sum, es);
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      @(negedge clk);
      chk("idle_after_handshake", in_ready, 1);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int  n_issue;
      int  res0;
      bit  r;
      bit  ok;
      rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
      do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 10);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0);

      // Abort a run in its third slice.
      @(posedge clk); #1;
      a = 32'hDEAD_BEEF; b = 32'h0123_4567; cin = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_sum", sum, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1;
      do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 0);

      // Back-to-back traffic: in_valid and out_ready held high.
      last_acc = -1;
      tput_mode = 1;
      res0 = n_res;
      n_issue = 0;
      @(posedge clk); #1;
      out_ready = 1; in_valid = 1;
      a = $urandom; b = $urandom; cin = 0;
      for (int i = 0; i < 80 && n_issue < 8; i++) begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk); #1;
         if (r) begin
            n_issue++;
            a = $urandom; b = $urandom; cin = n_issue[0];
         end
      end
      in_valid = 0;
      repeat (8) @(posedge clk);
      #1;
      chk("tput_issued", n_issue, 8);
      chk("tput_results", n_res - res0, n_issue);
      tput_mode = 0;
      out_ready = 0;

      // Randomized traffic with random backpressure.
      fork
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
         begin
            for (int k = 0; k < 40; k++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               a = pick_operand(); b = pick_operand(); cin = 1'($urandom);
               in_valid = 1;
               ok = 0;
               for (int i = 0; i < 60 && !ok; i++) begin
                  @(negedge clk);
                  r = in_ready;
                  @(posedge clk); #1;
                  ok = r;
               end
               chk("rnd_accept_timeout", ok, 1);
               in_valid = 0;
            end
            rnd_done = 1;
         end
      join
      @(posedge clk); #1;
      out_ready = 1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
